// File: rtl/ghost_mode_sched.sv
// ghost_mode_sched
//
// Global ghost-behaviour scheduler. It walks a level through WAIT and the
// arcade SCATTER/CHASE timetable and overlays a FRIGHTENED interval when a
// power pellet is eaten. It broadcasts one mode code, a reversal strobe and a
// flash warning to every ghost controller.
//
// Optional feature macro: GHOST_FRIGHT_EN
//   defined   : FRIGHT state, fright_cnt and fright_flash logic are built.
//   undefined : power_pellet_eaten is ignored, fright_flash is tied low and
//               ghost_mode never reports FRIGHTENED.
//
// Ports
//   Clk                in   system clock
//   Reset              in   asynchronous, active-high; clears all state
//   frame_tick         in   one-cycle pulse per video frame
//   PacmanCurrentDir   in   [3:0] Pac-Man direction, 0 = not yet moved
//   power_pellet_eaten in   one-cycle pulse
//   pacman_died        in   one-cycle pulse, restarts the level sequence
//   ghost_mode         out  [1:0] 0 WAIT, 1 CHASE, 2 SCATTER, 3 FRIGHTENED
//   reverse_pulse      out  one-cycle strobe: ghosts reverse direction
//   fright_flash       out  high during the last FLASH_SECONDS of FRIGHTENED
//   phase              out  [2:0] timetable index 0..7
//   fsm_state          out  [1:0] scheduler state (0 WAIT, 1 RUN, 2 FRIGHT)
//
// Handshake: there is none; every input is a single-cycle event sampled on
// the rising Clk edge, and every output is registered (latency one cycle).
module ghost_mode_sched #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int FRIGHT_SECONDS = 6,
  parameter int FLASH_SECONDS  = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [3:0] PacmanCurrentDir,
  input  logic       power_pellet_eaten,
  input  logic       pacman_died,
  output logic [1:0] ghost_mode,
  output logic       reverse_pulse,
  output logic       fright_flash,
  output logic [2:0] phase,
  output logic [1:0] fsm_state
);

  // Elaboration-time parameter sanity checks.
  if (FRAMES_PER_SEC < 1 || FRAMES_PER_SEC > 64) begin : g_bad_fps
    $error("ghost_mode_sched: FRAMES_PER_SEC must fit the 6-bit frame counter");
  end
  if (FRIGHT_SECONDS * FRAMES_PER_SEC > 1023) begin : g_bad_fright
    $error("ghost_mode_sched: FRIGHT_SECONDS*FRAMES_PER_SEC exceeds 1023");
  end
  if (FLASH_SECONDS > FRIGHT_SECONDS || FRIGHT_SECONDS < 1) begin : g_bad_flash
    $error("ghost_mode_sched: FLASH_SECONDS must not exceed FRIGHT_SECONDS");
  end

  localparam logic [5:0] FRAME_LAST = 6'(FRAMES_PER_SEC - 1);
  localparam logic [4:0] SEC_MAX    = 5'd31;
  localparam logic [2:0] PHASE_LAST = 3'd7;

  localparam logic [1:0] MODE_WAIT    = 2'd0;
  localparam logic [1:0] MODE_CHASE   = 2'd1;
  localparam logic [1:0] MODE_SCATTER = 2'd2;

`ifdef GHOST_FRIGHT_EN
  localparam logic [1:0] MODE_FRIGHT = 2'd3;
  localparam logic [9:0] FRIGHT_LAST =
    10'(FRIGHT_SECONDS * FRAMES_PER_SEC - 1);
  localparam logic [9:0] FLASH_START =
    10'((FRIGHT_SECONDS - FLASH_SECONDS) * FRAMES_PER_SEC);
`endif

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_RUN    = 2'd1
`ifdef GHOST_FRIGHT_EN
    ,S_FRIGHT = 2'd2
`endif
  } state_t;

  // Seconds spent in each timetable phase. Phase 7 never expires.
  function automatic logic [4:0] phase_dur(input logic [2:0] p);
    case (p)
      3'd0:    phase_dur = 5'd7;
      3'd1:    phase_dur = 5'd20;
      3'd2:    phase_dur = 5'd7;
      3'd3:    phase_dur = 5'd20;
      3'd4:    phase_dur = 5'd5;
      3'd5:    phase_dur = 5'd20;
      3'd6:    phase_dur = 5'd5;
      default: phase_dur = SEC_MAX;
    endcase
  endfunction

  state_t     state, state_nx;
  logic [5:0] frame_cnt, frame_nx;
  logic [4:0] sec_cnt, sec_nx;
  logic [2:0] phase_nx;
  logic [1:0] mode_nx;
  logic       rev_evt;
  logic       reverse_nx;
`ifdef GHOST_FRIGHT_EN
  logic [9:0] fright_cnt, fright_nx;
  logic       flash_nx;
`else
  logic       unused_pellet;
  assign unused_pellet = power_pellet_eaten;
`endif

  assign fsm_state = state;

  // ---------------------------------------------------------------------
  // Next-state and next-output logic.
  // Event priority: pacman_died > power_pellet_eaten > frame_tick. A pellet
  // taken in RUN pre-empts any counter advance (including a phase expiry)
  // in the same cycle, so the timetable position is frozen untouched.
  // ---------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    frame_nx = frame_cnt;
    sec_nx   = sec_cnt;
    phase_nx = phase;
    rev_evt  = 1'b0;
`ifdef GHOST_FRIGHT_EN
    fright_nx = fright_cnt;
`endif

    if (pacman_died) begin
      state_nx = S_WAIT;
      frame_nx = '0;
      sec_nx   = '0;
      phase_nx = '0;
`ifdef GHOST_FRIGHT_EN
      fright_nx = '0;
`endif
    end else begin
      case (state)
        S_WAIT: begin
          // Pellets are ignored here; first movement starts phase 0.
          if (PacmanCurrentDir != 4'd0) begin
            state_nx = S_RUN;
            frame_nx = '0;
            sec_nx   = '0;
            phase_nx = '0;
          end
        end

        S_RUN: begin
`ifdef GHOST_FRIGHT_EN
          if (power_pellet_eaten) begin
            state_nx  = S_FRIGHT;
            fright_nx = '0;
            rev_evt   = 1'b1;
          end else
`endif
          if (frame_tick) begin
            if (frame_cnt == FRAME_LAST) begin
              frame_nx = '0;
              if (phase != PHASE_LAST &&
                  (sec_cnt + 5'd1) == phase_dur(phase)) begin
                phase_nx = phase + 3'd1;
                sec_nx   = '0;
                rev_evt  = 1'b1;
              end else if (sec_cnt != SEC_MAX) begin
                // Saturates in phase 7, where nothing else depends on it.
                sec_nx = sec_cnt + 5'd1;
              end
            end else begin
              frame_nx = frame_cnt + 6'd1;
            end
          end
        end

`ifdef GHOST_FRIGHT_EN
        S_FRIGHT: begin
          // Timetable counters stay frozen for the whole interval.
          if (power_pellet_eaten) begin
            fright_nx = '0;
            rev_evt   = 1'b1;
          end else if (frame_tick) begin
            if (fright_cnt == FRIGHT_LAST) begin
              state_nx  = S_RUN;
              fright_nx = '0;
            end else begin
              fright_nx = fright_cnt + 10'd1;
            end
          end
        end
`endif

        default: begin
          state_nx = S_WAIT;
          frame_nx = '0;
          sec_nx   = '0;
          phase_nx = '0;
        end
      endcase
    end

    // Outputs are derived from the next state so they register together.
    case (state_nx)
      S_RUN:   mode_nx = phase_nx[0] ? MODE_CHASE : MODE_SCATTER;
`ifdef GHOST_FRIGHT_EN
      S_FRIGHT: mode_nx = MODE_FRIGHT;
`endif
      default: mode_nx = MODE_WAIT;
    endcase

`ifdef GHOST_FRIGHT_EN
    flash_nx = (state_nx == S_FRIGHT) && (fright_nx >= FLASH_START);
`endif

    // Back-to-back reversal events (e.g. a phase expiry followed by a
    // pellet on the very next cycle) collapse into one strobe so ghosts
    // never see the strobe held for two cycles.
    reverse_nx = rev_evt && !reverse_pulse;
  end

  // ---------------------------------------------------------------------
  // State and output registers.
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= S_WAIT;
      frame_cnt     <= '0;
      sec_cnt       <= '0;
      phase         <= '0;
      ghost_mode    <= MODE_WAIT;
      reverse_pulse <= 1'b0;
    end else begin
      state         <= state_nx;
      frame_cnt     <= frame_nx;
      sec_cnt       <= sec_nx;
      phase         <= phase_nx;
      ghost_mode    <= mode_nx;
      reverse_pulse <= reverse_nx;
    end
  end

`ifdef GHOST_FRIGHT_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fright_cnt   <= '0;
      fright_flash <= 1'b0;
    end else begin
      fright_cnt   <= fright_nx;
      fright_flash <= flash_nx;
    end
  end
`else
  assign fright_flash = 1'b0;
`endif

endmodule

// File: tb/tb_ghost_mode_sched.sv
// Directed bench for ghost_mode_sched, run with FRAMES_PER_SEC = 4 so the
// whole timetable is short (phase lengths 28/80/28/80/20/80/20 ticks).
// FRIGHT interval = 24 ticks, flash starts at fright tick 16.
module tb_ghost_mode_sched;

  localparam int FPS = 4;

  logic       Clk;
  logic       Reset;
  logic       frame_tick;
  logic [3:0] PacmanCurrentDir;
  logic       power_pellet_eaten;
  logic       pacman_died;
  logic [1:0] ghost_mode;
  logic       reverse_pulse;
  logic       fright_flash;
  logic [2:0] phase;
  logic [1:0] fsm_state;

  int vectors;
  int miscompares;
  int rev_count;

  ghost_mode_sched #(
    .FRAMES_PER_SEC(FPS),
    .FRIGHT_SECONDS(6),
    .FLASH_SECONDS (2)
  ) dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .frame_tick        (frame_tick),
    .PacmanCurrentDir  (PacmanCurrentDir),
    .power_pellet_eaten(power_pellet_eaten),
    .pacman_died       (pacman_died),
    .ghost_mode        (ghost_mode),
    .reverse_pulse     (reverse_pulse),
    .fright_flash      (fright_flash),
    .phase             (phase),
    .fsm_state         (fsm_state)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Driver tasks: inputs change 1 ns after the rising edge; outputs are
  // sampled at the same point, reflecting the previous cycle's inputs.
  task automatic cycle();
    @(posedge Clk);
    #1;
    if (reverse_pulse === 1'b1) rev_count++;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
      cycle();
    end
  endtask

  task automatic pulse_pellet(input logic with_tick);
    power_pellet_eaten = 1'b1;
    frame_tick         = with_tick;
    cycle();
    power_pellet_eaten = 1'b0;
    frame_tick         = 1'b0;
  endtask

  task automatic restart_level();
    pacman_died = 1'b1;
    cycle();
    pacman_died      = 1'b0;
    PacmanCurrentDir = 4'd3;
    cycle();
    rev_count = 0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    frame_tick = 1'b0; PacmanCurrentDir = 4'd0;
    power_pellet_eaten = 1'b0; pacman_died = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    cycle();
    vectors++;
    if ({ghost_mode, reverse_pulse, fright_flash, phase, fsm_state} !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_values: got mode=%0d rev=%0b flash=%0b phase=%0d st=%0d expected all 0",
               ghost_mode, reverse_pulse, fright_flash, phase, fsm_state);
    end
    // Ticks and pellets in WAIT change nothing.
    rev_count = 0;
    run_ticks(10);
    pulse_pellet(1'b0);
    cycle();
    vectors++;
    if (ghost_mode !== 2'd0 || phase !== 3'd0 || rev_count != 0) begin
      miscompares++;
      $display("FAIL wait_hold: got mode=%0d phase=%0d revs=%0d expected 0/0/0",
               ghost_mode, phase, rev_count);
    end
  endtask

  task automatic test_wait_exit();
    PacmanCurrentDir = 4'd3;
    cycle();
    vectors++;
    if (ghost_mode !== 2'd2 || phase !== 3'd0 || reverse_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_exit: got mode=%0d phase=%0d rev=%0b expected 2/0/0",
               ghost_mode, phase, reverse_pulse);
    end
    rev_count = 0;
    run_ticks(7 * FPS - 1);
    vectors++;
    if (ghost_mode !== 2'd2 || phase !== 3'd0 || rev_count != 0) begin
      miscompares++;
      $display("FAIL phase0_hold: got mode=%0d phase=%0d revs=%0d expected 2/0/0",
               ghost_mode, phase, rev_count);
    end
    run_ticks(1);
    vectors++;
    if (ghost_mode !== 2'd1 || phase !== 3'd1 || rev_count != 1) begin
      miscompares++;
      $display("FAIL phase0_expire: got mode=%0d phase=%0d revs=%0d expected 1/1/1",
               ghost_mode, phase, rev_count);
    end
  endtask

  // Continues from phase 1 just entered.
  task automatic test_timetable();
    int dur[7];
    int revs_before;
    logic [2:0] p_exp;
    logic [1:0] m_exp;
    dur = '{7, 20, 7, 20, 5, 20, 5};
    for (int p = 1; p < 7; p++) begin
      revs_before = rev_count;
      run_ticks(dur[p] * FPS - 1);
      p_exp = 3'(p);
      vectors++;
      if (phase !== p_exp || rev_count != revs_before) begin
        miscompares++;
        $display("FAIL phase%0d_hold: got phase=%0d revs=%0d expected %0d/%0d",
                 p, phase, rev_count - revs_before, p, 0);
      end
      run_ticks(1);
      p_exp = 3'(p + 1);
      m_exp = ((p + 1) % 2 == 1) ? 2'd1 : 2'd2;
      vectors++;
      if (phase !== p_exp || ghost_mode !== m_exp || rev_count != revs_before + 1) begin
        miscompares++;
        $display("FAIL phase%0d_expire: got phase=%0d mode=%0d revs=%0d expected %0d/%0d/1",
                 p, phase, ghost_mode, rev_count - revs_before, p + 1, m_exp);
      end
    end
    revs_before = rev_count;
    run_ticks(1000);
    vectors++;
    if (phase !== 3'd7 || ghost_mode !== 2'd1 || rev_count != revs_before) begin
      miscompares++;
      $display("FAIL phase7_hold: got phase=%0d mode=%0d revs=%0d expected 7/1/0",
               phase, ghost_mode, rev_count - revs_before);
    end
  endtask

  task automatic test_died();
    pacman_died = 1'b1;
    power_pellet_eaten = 1'b1;
    frame_tick = 1'b1;
    cycle();
    pacman_died = 1'b0; power_pellet_eaten = 1'b0; frame_tick = 1'b0;
    PacmanCurrentDir = 4'd0;
    vectors++;
    if (ghost_mode !== 2'd0 || phase !== 3'd0 || fright_flash !== 1'b0 ||
        reverse_pulse !== 1'b0 || fsm_state !== 2'd0) begin
      miscompares++;
      $display("FAIL died: got mode=%0d phase=%0d flash=%0b rev=%0b st=%0d expected 0/0/0/0/0",
               ghost_mode, phase, fright_flash, reverse_pulse, fsm_state);
    end
  endtask

  task automatic test_async_reset();
    restart_level();
    run_ticks(30);
    #2 Reset = 1'b1;
    #1;
    vectors++;
    if (ghost_mode !== 2'd0 || phase !== 3'd0 || fsm_state !== 2'd0) begin
      miscompares++;
      $display("FAIL async_reset: got mode=%0d phase=%0d st=%0d expected 0/0/0",
               ghost_mode, phase, fsm_state);
    end
    @(posedge Clk); #1 Reset = 1'b0;
  endtask

`ifdef GHOST_FRIGHT_EN
  task automatic test_fright();
    restart_level();
    run_ticks(10);
    pulse_pellet(1'b0);
    vectors++;
    if (ghost_mode !== 2'd3 || reverse_pulse !== 1'b1 || fright_flash !== 1'b0) begin
      miscompares++;
      $display("FAIL fright_enter: got mode=%0d rev=%0b flash=%0b expected 3/1/0",
               ghost_mode, reverse_pulse, fright_flash);
    end
    run_ticks(15);
    vectors++;
    if (fright_flash !== 1'b0 || ghost_mode !== 2'd3) begin
      miscompares++;
      $display("FAIL flash_early: got flash=%0b mode=%0d expected 0/3", fright_flash, ghost_mode);
    end
    run_ticks(1);
    vectors++;
    if (fright_flash !== 1'b1) begin
      miscompares++;
      $display("FAIL flash_rise: got %0b expected 1", fright_flash);
    end
    rev_count = 0;
    run_ticks(8);
    vectors++;
    if (ghost_mode !== 2'd2 || fright_flash !== 1'b0 || phase !== 3'd0 || rev_count != 0) begin
      miscompares++;
      $display("FAIL fright_exit: got mode=%0d flash=%0b phase=%0d revs=%0d expected 2/0/0/0",
               ghost_mode, fright_flash, phase, rev_count);
    end
    run_ticks(17);
    vectors++;
    if (phase !== 3'd0) begin
      miscompares++;
      $display("FAIL frozen_phase0: got phase=%0d expected 0", phase);
    end
    run_ticks(1);
    vectors++;
    if (phase !== 3'd1) begin
      miscompares++;
      $display("FAIL resumed_expire: got phase=%0d expected 1", phase);
    end
  endtask

  task automatic test_back_to_back();
    restart_level();
    run_ticks(10);
    pulse_pellet(1'b1);
    run_ticks(20);
    vectors++;
    if (fright_flash !== 1'b1) begin
      miscompares++;
      $display("FAIL flash_before_repeat: got %0b expected 1", fright_flash);
    end
    pulse_pellet(1'b0);
    vectors++;
    if (reverse_pulse !== 1'b1 || fright_flash !== 1'b0 || ghost_mode !== 2'd3) begin
      miscompares++;
      $display("FAIL repeat_pellet: got rev=%0b flash=%0b mode=%0d expected 1/0/3",
               reverse_pulse, fright_flash, ghost_mode);
    end
    run_ticks(15);
    vectors++;
    if (fright_flash !== 1'b0) begin
      miscompares++;
      $display("FAIL repeat_flash_early: got %0b expected 0", fright_flash);
    end
    run_ticks(9);
    vectors++;
    if (ghost_mode !== 2'd2) begin
      miscompares++;
      $display("FAIL repeat_exit: got mode=%0d expected 2", ghost_mode);
    end
    run_ticks(17);
    vectors++;
    if (phase !== 3'd0) begin
      miscompares++;
      $display("FAIL consumed_tick: got phase=%0d expected 0", phase);
    end
    run_ticks(1);
    vectors++;
    if (phase !== 3'd1) begin
      miscompares++;
      $display("FAIL consumed_expire: got phase=%0d expected 1", phase);
    end
    // Enter FRIGHT again, then die together with a pellet.
    pulse_pellet(1'b0);
    test_died();
  endtask
`else
  task automatic test_pellet_ignored();
    restart_level();
    run_ticks(10);
    pulse_pellet(1'b0);
    vectors++;
    if (ghost_mode !== 2'd2 || fright_flash !== 1'b0 || reverse_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL pellet_ignored: got mode=%0d flash=%0b rev=%0b expected 2/0/0",
               ghost_mode, fright_flash, reverse_pulse);
    end
    // Without the fright overlay a coincident pellet does not eat the tick.
    pulse_pellet(1'b1);
    cycle();
    run_ticks(16);
    vectors++;
    if (phase !== 3'd0 || ghost_mode !== 2'd2 || rev_count != 0) begin
      miscompares++;
      $display("FAIL nofright_hold: got phase=%0d mode=%0d revs=%0d expected 0/2/0",
               phase, ghost_mode, rev_count);
    end
    run_ticks(1);
    vectors++;
    if (phase !== 3'd1 || ghost_mode !== 2'd1 || rev_count != 1) begin
      miscompares++;
      $display("FAIL nofright_expire: got phase=%0d mode=%0d revs=%0d expected 1/1/1",
               phase, ghost_mode, rev_count);
    end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    rev_count = 0;
    test_reset();
    test_wait_exit();
    test_timetable();
    test_died();
    test_async_reset();
`ifdef GHOST_FRIGHT_EN
    test_fright();
    test_back_to_back();
`else
    test_pellet_ignored();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
